// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared definitions for the bit-serial ALU family.
//   state_t        : sequencer states (ST_IDLE=0, ST_RUN=1, ST_DONE=2)
//   DEFAULT_WIDTH  : default operand/result width
//   OP_ADD/OP_SUB  : op encoding on the sub input, kept here so later serial
//                    ops (logic, shift) share one encoding
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_add_1bit.sv
// add_1bit
// One-bit full adder cell: the only arithmetic in the serial adder/subtractor.
// Ports:
//   x, y  : operand bits
//   c_in  : carry in
//   z     : sum bit
//   c_out : carry out
module add_1bit (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic z,
  output logic c_out
);

  assign z     = x ^ y ^ c_in;
  assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial two's-complement adder/subtractor. Operands are captured on start
// and pushed LSB-first through a single add_1bit cell, one bit per clock. The
// result and flags are registered when the last bit has been processed.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request, honoured only in IDLE or DONE
//   sub     : 0 = a+b, 1 = a-b (captured with start)
//   a, b    : operands (captured with start)
//   busy    : high while bits are being processed
//   done    : one-cycle completion pulse
//   result  : sum/difference, held until the next completion
//   c_out   : carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf     : signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits produced so far, MSB-aligned; the bit being
  // produced this cycle is concatenated on top to form the full word.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_z;
  logic             fa_c;
  logic             last_bit;
  logic             accept;

  add_1bit u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .c_in  (carry),
    .z     (fa_z),
    .c_out (fa_c)
  );

  assign last_bit = (count == CW'(WIDTH - 1));
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign sum_next = {fa_z, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = start ? ST_RUN : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: b is inverted at capture and the +1 enters as
  // the initial carry. The carry register always holds the carry into the bit
  // currently at the LSB, so on the last bit it is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b ^ {WIDTH{sub == OP_SUB}};
      sum_sh <= '0;
      carry  <= (sub == OP_SUB);
      count  <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_next[WIDTH-1:1];
      carry  <= fa_c;
      count  <= count + 1'b1;
      if (last_bit) begin
        result <= sum_next;
        c_out  <= fa_c;
        ovf    <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Scoreboard bench for serial_addsub (WIDTH=8). Stimulus pushes the expected
// response of every accepted operation; a monitor pops on each done pulse and
// also checks output hold, busy length and busy/done exclusivity.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t last_exp;
  int   busy_run;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   ux, uy, sx, sy, us, ss;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      us  = ux - uy;
      ss  = sx - sy;
      e.c = (ux >= uy);
    end else begin
      us  = ux + uy;
      ss  = sx + sy;
      e.c = (us >= (1 << W));
    end
    e.res = us[W-1:0];
    e.o   = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.o   = o;
    return e;
  endfunction

  // Monitor: all output checks happen on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_exp = mk('0, 1'b0, 1'b0);
      busy_run = 0;
    end else begin
      if (busy && done) check_output("busy_done_exclusive", 32'(1), 32'(0));
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check_output("result", 32'(result), 32'(e.res));
          check_output("c_out", 32'(c_out), 32'(e.c));
          check_output("ovf", 32'(ovf), 32'(e.o));
          check_output("busy_cycles", 32'(busy_run), 32'(W));
          last_exp = e;
        end
        busy_run = 0;
      end else begin
        check_output("result_hold", 32'(result), 32'(last_exp.res));
        check_output("flags_hold", 32'({c_out, ovf}), 32'({last_exp.c, last_exp.o}));
      end
    end
  end

  // Drives one start pulse and records the expected response.
  task automatic apply_stimulus(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_output("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic         s;
    logic [W-1:0] x, y;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check_output("reset_busy", 32'(busy), 32'(0));
    check_output("reset_done", 32'(done), 32'(0));
    check_output("reset_result", 32'(result), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    apply_stimulus(1'b0, 8'h3C, 8'h15, mk(8'h51, 1'b0, 1'b0)); wait_done();
    apply_stimulus(1'b0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1)); wait_done();
    apply_stimulus(1'b0, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0)); wait_done();
    apply_stimulus(1'b1, 8'h05, 8'h07, mk(8'hFE, 1'b0, 1'b0)); wait_done();
    apply_stimulus(1'b1, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1)); wait_done();

    // A start during RUN must be ignored.
    apply_stimulus(1'b0, 8'h3C, 8'h15, mk(8'h51, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (W + 3) @(negedge clk);

    // Back-to-back: start held on the done cycle.
    apply_stimulus(1'b0, 8'h01, 8'h01, mk(8'h02, 1'b0, 1'b0));
    wait_done();
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h10;
    b     = 8'h20;
    sb.push_back(mk(8'h30, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check_output("b2b_busy", 32'(busy), 32'(1));
    wait_done();
    @(negedge clk);

    // Reset in the middle of a RUN aborts with no done.
    apply_stimulus(1'b0, 8'h12, 8'h34, mk(8'h46, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_output("abort_busy", 32'(busy), 32'(0));
    check_output("abort_done", 32'(done), 32'(0));
    check_output("abort_result", 32'(result), 32'(0));
    check_output("abort_flags", 32'({c_out, ovf}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    apply_stimulus(1'b1, 8'h40, 8'h41, mk(8'hFF, 1'b0, 1'b0)); wait_done();

    // Randomized operations checked against the integer model.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      apply_stimulus(s, x, y, model(s, x, y));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
